// File: rtl/par2ser_pkg.sv
// par2ser_pkg: shared types and constants for the par2ser_tx serializer.
//   state_t       FSM state encoding (IDLE, SHIFT, PAR)
//   clog2_w()     bit counter width for a given word width
//   PAR_BIT_EVEN  seed value for the even-parity XOR reduction
package par2ser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;

  localparam logic PAR_BIT_EVEN = 1'b0;

  // Smallest r with 2**r >= width; for width >= 2 this is at least 1.
  function automatic int clog2_w(input int width);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < width) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/par2ser_tx.sv
// par2ser_tx: parallel-to-serial transmitter, send end of the 1-bit serial lane.
// Takes one DWIDTH-bit word per din_vld/din_rdy handshake and emits it one bit
// per clk on dout, with dout_sof flagging the first bit of each frame.
//
// Optional feature macro: PAR2SER_PARITY_EN
//   defined   -> one extra even-parity bit follows every frame (PAR state)
//   undefined -> frame is exactly DWIDTH bits
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   din       in   [DWIDTH-1:0] parallel word
//   din_vld   in   din is valid
//   din_rdy   out  word can be accepted this cycle (combinational, state/counter only)
//   dout      out  serial data bit (registered)
//   dout_vld  out  dout carries a valid bit (registered)
//   dout_sof  out  dout is bit 0 of a frame (registered)
//   busy      out  frame in progress (registered)
//
// state | meaning
// IDLE  | no frame; din_rdy=1
// SHIFT | data bits on dout, counter 0..DWIDTH-1
// PAR   | parity bit on dout (PAR2SER_PARITY_EN only); din_rdy=1
module par2ser_tx
  import par2ser_pkg::*;
#(
  parameter int DWIDTH    = 32,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DWIDTH-1:0] din,
  input  logic              din_vld,
  output logic              din_rdy,
  output logic              dout,
  output logic              dout_vld,
  output logic              dout_sof,
  output logic              busy
);

  localparam int            CW       = clog2_w(DWIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DWIDTH - 1);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DWIDTH-1:0] sreg_q, sreg_d;
  logic              dout_d, vld_d, sof_d, busy_d;
  logic              load, start;
`ifdef PAR2SER_PARITY_EN
  logic              par_q, par_d;
`endif

`ifdef PAR2SER_PARITY_EN
  assign din_rdy = (state_q == IDLE) || (state_q == PAR);
`else
  assign din_rdy = (state_q == IDLE) || ((state_q == SHIFT) && (cnt_q == CNT_LAST));
`endif

  assign load = din_vld && din_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sreg_q   <= '0;
      dout     <= 1'b0;
      dout_vld <= 1'b0;
      dout_sof <= 1'b0;
      busy     <= 1'b0;
`ifdef PAR2SER_PARITY_EN
      par_q    <= PAR_BIT_EVEN;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sreg_q   <= sreg_d;
      dout     <= dout_d;
      dout_vld <= vld_d;
      dout_sof <= sof_d;
      busy     <= busy_d;
`ifdef PAR2SER_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  // The first bit goes straight to dout at load, so the shift register only
  // holds the remaining bits, pre-shifted by one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    dout_d  = 1'b0;
    vld_d   = 1'b0;
    sof_d   = 1'b0;
    busy_d  = 1'b0;
    start   = 1'b0;
`ifdef PAR2SER_PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      IDLE: begin
        start = load;
      end
      SHIFT: begin
        if (cnt_q == CNT_LAST) begin
`ifdef PAR2SER_PARITY_EN
          state_d = PAR;
          dout_d  = par_q;
          vld_d   = 1'b1;
          busy_d  = 1'b1;
`else
          start   = load;
          state_d = IDLE;
          cnt_d   = '0;
`endif
        end else begin
          dout_d = MSB_FIRST ? sreg_q[DWIDTH-1] : sreg_q[0];
          sreg_d = MSB_FIRST ? (sreg_q << 1) : (sreg_q >> 1);
          cnt_d  = cnt_q + 1'b1;
          vld_d  = 1'b1;
          busy_d = 1'b1;
        end
      end
`ifdef PAR2SER_PARITY_EN
      PAR: begin
        start   = load;
        state_d = IDLE;
        cnt_d   = '0;
      end
`endif
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (start) begin
      state_d = SHIFT;
      cnt_d   = '0;
      sreg_d  = MSB_FIRST ? (din << 1) : (din >> 1);
      dout_d  = MSB_FIRST ? din[DWIDTH-1] : din[0];
      vld_d   = 1'b1;
      sof_d   = 1'b1;
      busy_d  = 1'b1;
`ifdef PAR2SER_PARITY_EN
      par_d   = PAR_BIT_EVEN ^ (^din);
`endif
    end
  end

endmodule

// File: tb/tb_par2ser_tx.sv
// tb_par2ser_tx: self-checking bench for par2ser_tx (DWIDTH=8).
// dut_a sends MSB first, dut_b sends LSB first. Expected {bit, sof} pairs are
// queued at each handshake and popped as dout_vld bits appear.
// Honours PAR2SER_PARITY_EN (adds the parity bit to each expected frame).
module tb_par2ser_tx;

`ifdef PAR2SER_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  logic       clk, rst_n;
  logic [7:0] din_a, din_b;
  logic       din_vld_a, din_vld_b;
  logic       din_rdy_a, din_rdy_b;
  logic       dout_a, dout_b, dout_vld_a, dout_vld_b;
  logic       dout_sof_a, dout_sof_b, busy_a, busy_b;

  par2ser_tx #(.DWIDTH(8), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .din(din_a), .din_vld(din_vld_a), .din_rdy(din_rdy_a),
    .dout(dout_a), .dout_vld(dout_vld_a), .dout_sof(dout_sof_a), .busy(busy_a));

  par2ser_tx #(.DWIDTH(8), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .din(din_b), .din_vld(din_vld_b), .din_rdy(din_rdy_b),
    .dout(dout_b), .dout_vld(dout_vld_b), .dout_sof(dout_sof_b), .busy(busy_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] din;
    logic       sel;   // 0: dut_a (MSB first), 1: dut_b (LSB first)
    logic [7:0] seq;   // bits in transmit order, seq[7] sent first
    logic       par;
  } vec_t;

  vec_t       tbl[7];
  logic [1:0] q_a[$];
  logic [1:0] q_b[$];
  logic [7:0] exp_seq_a, exp_seq_b;
  logic       exp_par_a, exp_par_b;
  logic       hs_a, hs_b;
  int         nvec, nfail;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: check outputs and record handshakes at the negedge, then
  // return 1 time unit after the following posedge.
  task automatic cyc();
    logic [1:0] e;
    @(negedge clk);
    if (dout_vld_a) begin
      chk("a_bit_expected", int'(q_a.size() != 0), 1);
      if (q_a.size() != 0) begin
        e = q_a.pop_front();
        chk("a_dout", int'(dout_a), int'(e[1]));
        chk("a_sof", int'(dout_sof_a), int'(e[0]));
      end
    end
    if (dout_vld_b) begin
      chk("b_bit_expected", int'(q_b.size() != 0), 1);
      if (q_b.size() != 0) begin
        e = q_b.pop_front();
        chk("b_dout", int'(dout_b), int'(e[1]));
        chk("b_sof", int'(dout_sof_b), int'(e[0]));
      end
    end
    hs_a = din_vld_a && din_rdy_a;
    hs_b = din_vld_b && din_rdy_b;
    if (hs_a) begin
      for (int i = 0; i < 8; i++) q_a.push_back({exp_seq_a[7-i], (i == 0)});
`ifdef PAR2SER_PARITY_EN
      q_a.push_back({exp_par_a, 1'b0});
`endif
    end
    if (hs_b) begin
      for (int i = 0; i < 8; i++) q_b.push_back({exp_seq_b[7-i], (i == 0)});
`ifdef PAR2SER_PARITY_EN
      q_b.push_back({exp_par_b, 1'b0});
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic sel, input logic [7:0] d, input logic [7:0] seq, input logic par);
    int n;
    if (sel) begin din_b = d; exp_seq_b = seq; exp_par_b = par; din_vld_b = 1'b1; end
    else     begin din_a = d; exp_seq_a = seq; exp_par_a = par; din_vld_a = 1'b1; end
    n = 0;
    do begin
      cyc();
      n++;
    end while (!(sel ? hs_b : hs_a) && n < 20);
    chk("send_accepted", int'(sel ? hs_b : hs_a), 1);
    din_vld_a = 1'b0;
    din_vld_b = 1'b0;
  endtask

  // Called just after the handshake edge: walks the frame checking din_rdy/busy.
  task automatic run_frame(input logic sel);
    for (int i = 0; i < FL; i++) begin
      chk("frame_rdy", int'(sel ? din_rdy_b : din_rdy_a), int'(i == FL - 1));
      chk("frame_busy", int'(sel ? busy_b : busy_a), 1);
      cyc();
    end
    chk("idle_vld", int'(sel ? dout_vld_b : dout_vld_a), 0);
    chk("idle_dout", int'(sel ? dout_b : dout_a), 0);
    chk("idle_busy", int'(sel ? busy_b : busy_a), 0);
    chk("idle_rdy", int'(sel ? din_rdy_b : din_rdy_a), 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0 || busy_a || busy_b) && n < 100) begin
      cyc();
      n++;
    end
    chk("drain_in_time", int'(n < 100), 1);
  endtask

  function automatic logic [7:0] model_seq(input logic [7:0] d, input logic msb);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = msb ? d[i] : d[7-i];
    return r;
  endfunction

  initial begin
    int nv, nb;
    nvec = 0; nfail = 0;
    hs_a = 1'b0; hs_b = 1'b0;
    exp_seq_a = '0; exp_seq_b = '0; exp_par_a = 1'b0; exp_par_b = 1'b0;
    din_a = '0; din_b = '0; din_vld_a = 1'b0; din_vld_b = 1'b0;

    tbl[0] = '{din: 8'hA5, sel: 1'b0, seq: 8'hA5, par: 1'b0};
    tbl[1] = '{din: 8'h01, sel: 1'b1, seq: 8'h80, par: 1'b1};
    tbl[2] = '{din: 8'h07, sel: 1'b0, seq: 8'h07, par: 1'b1};
    tbl[3] = '{din: 8'h03, sel: 1'b0, seq: 8'h03, par: 1'b0};
    tbl[4] = '{din: 8'h80, sel: 1'b1, seq: 8'h01, par: 1'b1};
    tbl[5] = '{din: 8'h5A, sel: 1'b1, seq: 8'h5A, par: 1'b0};
    tbl[6] = '{din: 8'hC3, sel: 1'b0, seq: 8'hC3, par: 1'b0};

    rst_n = 1'b0;
    #22 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_rdy", int'(din_rdy_a), 1);
    chk("rst_dout", int'(dout_a), 0);
    chk("rst_vld", int'(dout_vld_a), 0);
    chk("rst_sof", int'(dout_sof_a), 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_vld_b", int'(dout_vld_b), 0);

    // Table: single frames on either bit order.
    foreach (tbl[k]) begin
      send(tbl[k].sel, tbl[k].din, tbl[k].seq, tbl[k].par);
      run_frame(tbl[k].sel);
    end
    drain();

    // Back-to-back FF then 00 on dut_a with din_vld held high.
    din_a = 8'hFF; exp_seq_a = 8'hFF; exp_par_a = 1'b0; din_vld_a = 1'b1;
    nb = 0;
    do begin cyc(); nb++; end while (!hs_a && nb < 20);
    chk("b2b_first_accept", int'(hs_a), 1);
    din_a = 8'h00; exp_seq_a = 8'h00; exp_par_a = 1'b0;
    nv = 0; nb = 0;
    for (int i = 0; i < 2 * FL; i++) begin
      if (dout_vld_a) nv++;
      if (busy_a) nb++;
      cyc();
      if (hs_a) begin
        chk("b2b_second_at", i, FL - 1);
        din_vld_a = 1'b0;
      end
    end
    chk("b2b_contig_vld", nv, 2 * FL);
    chk("b2b_busy", nb, 2 * FL);
    chk("b2b_end_vld", int'(dout_vld_a), 0);
    drain();

    // Stall: new word offered mid-frame must wait for the last bit slot.
    send(1'b0, 8'h3C, model_seq(8'h3C, 1'b1), ^(8'h3C));
    din_a = 8'h99; exp_seq_a = model_seq(8'h99, 1'b1); exp_par_a = ^(8'h99);
    din_vld_a = 1'b1;
    for (int i = 0; i < FL; i++) begin
      chk("stall_rdy", int'(din_rdy_a), int'(i == FL - 1));
      cyc();
      chk("stall_accept", int'(hs_a), int'(i == FL - 1));
      if (hs_a) din_vld_a = 1'b0;
    end
    din_vld_a = 1'b0;
    run_frame(1'b0);
    drain();

    // Reset mid-frame after bit 3 of C3.
    send(1'b0, 8'hC3, 8'hC3, 1'b0);
    repeat (3) cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_dout", int'(dout_a), 0);
    chk("arst_vld", int'(dout_vld_a), 0);
    chk("arst_sof", int'(dout_sof_a), 0);
    chk("arst_busy", int'(busy_a), 0);
    q_a.delete();
    q_b.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < FL + 2; i++) begin
      chk("post_rst_rdy", int'(din_rdy_a), 1);
      chk("post_rst_vld", int'(dout_vld_a), 0);
      cyc();
    end

    // Frame still works after reset.
    send(1'b1, 8'h6E, model_seq(8'h6E, 1'b0), ^(8'h6E));
    run_frame(1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/par2ser_tx.md
Name: par2ser_tx

Overview:
Parallel-to-serial transmitter. It is the send end of the serial link whose receive end is the existing serial-in/parallel-out block (1-bit in, DWIDTH-bit out).
- Accepts one DWIDTH-bit word per valid/ready handshake.
- Shifts the word out one bit per clk, with a frame-start marker.
- Sits between the parallel datapath and the single-bit serial lane.

Parameters:
- DWIDTH, 32, word width in bits; legal range 2..64.
- MSB_FIRST, 1, 1 = bit DWIDTH-1 is sent first; 0 = bit 0 is sent first.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- din  input  DWIDTH  parallel word to send.
- din_vld  input  1  din is valid.
- din_rdy  output  1  block can accept din this cycle.
- dout  output  1  serial data bit.
- dout_vld  output  1  dout carries a valid bit.
- dout_sof  output  1  dout is the first bit of a frame.
- busy  output  1  a frame is in progress.

Behaviour:
- Reset: rst_n low asynchronously forces state IDLE, dout=0, dout_vld=0, dout_sof=0, busy=0, bit counter=0, shift register=0.
- Reset mid-frame aborts the frame. No partial bits are sent after release.
- States:
  - IDLE: din_rdy=1. On din_vld&din_rdy, load the shift register from din and go to SHIFT.
  - SHIFT: one bit per cycle; the counter runs 0..DWIDTH-1.
  - PAR: present only with the optional feature.
- All outputs except din_rdy are registered. din_rdy is combinational from state and counter only, never from din_vld.
- Latency: handshake at edge k. First bit appears on dout after edge k, with dout_vld=1 and dout_sof=1. Bit i appears after edge k+i. The last data bit appears after edge k+DWIDTH-1.
- dout_sof is high only for bit 0 of a frame.
- busy=1 from the edge after the handshake until the last bit of the frame has been presented.
- Bit order:
  - MSB_FIRST=1: din[DWIDTH-1] first, shift left.
  - MSB_FIRST=0: din[0] first, shift right.
- Back-to-back: din_rdy=1 in SHIFT when counter==DWIDTH-1 (and no parity stage). A handshake there reloads the shift register, resets the counter to 0 and reasserts dout_sof. This gives zero idle cycles between frames.
- Without a new word at the last bit, return to IDLE. dout_vld=0 and dout=0 from the next edge.
- din is sampled only at the handshake edge. Changes to din mid-frame have no effect.
- din_vld high while din_rdy=0: no effect. The upstream must hold din and din_vld until din_rdy.
- Counter width is $clog2(DWIDTH). It wraps only via explicit reload, never by overflow.

Optional Feature:
- Macro: PAR2SER_PARITY_EN.
- Defined:
  - After the last data bit, state PAR sends one extra bit: dout = even parity (XOR reduction) of the frame word, captured at load, with dout_vld=1 and dout_sof=0.
  - The frame is DWIDTH+1 cycles.
  - din_rdy is high in PAR instead of at the last data bit, so back-to-back is still zero-gap.
  - busy covers the parity cycle.
- Undefined: no PAR state and no parity register. Frame is DWIDTH cycles.

Decomposition:
- Package par2ser_pkg:
  - state enum (IDLE, SHIFT, PAR);
  - function clog2_w(DWIDTH) for counter width;
  - constant PAR_BIT_EVEN = 1'b0 (parity init).
- No sub-module. The FSM, counter and shift register stay in one module, which is about 150 lines of RTL.

Test Plan:
- Single word, DWIDTH=8, MSB_FIRST=1, din=8'hA5 held 1 cycle with din_vld:
  - dout sequence 1,0,1,0,0,1,0,1 on 8 consecutive cycles with dout_vld=1;
  - dout_sof only on the first bit;
  - din_rdy low for cycles 1..7 of the frame;
  - then IDLE with dout_vld=0.
- MSB_FIRST=0, din=8'h01: dout = 1 then seven 0s.
- Back-to-back, din_vld held high with 8'hFF then 8'h00:
  - 16 contiguous valid bits (eight 1s then eight 0s);
  - dout_sof on cycles 1 and 9;
  - no gap; busy stays high for all 16 cycles.
- Stall: din_vld asserted mid-frame with new data. Not accepted until the last bit cycle; current frame bits unchanged.
- Reset mid-frame: rst_n low after bit 3 of 8'hC3.
  - Outputs go to 0 immediately, asynchronously.
  - After release: IDLE, din_rdy=1, no residual bits.
- PAR2SER_PARITY_EN defined:
  - din=8'h07 gives 9 bits with a last bit of 1;
  - din=8'h03 gives a last bit of 0;
  - back-to-back frames are 9 cycles apart.
